result_deser: RTL and testbench
===============================

# result_deser

Serial-to-parallel result receiver for the bit-serial CPU. It consumes the LSB-first result stream that the control FSM emits during its write-out phase (`shift_out` strobe plus data bit) and assembles it into a `WIDTH`-bit word. On `load_out` it commits the word, the final carry and a zero flag into an output register. A valid/ready handshake presents the committed result to the display/host side.

## Interface
- `WIDTH`, 8, result width in bits; equals the datapath width.
- `clk` input 1, single system clock; all state changes on the rising edge.
- `rstn` input 1, asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `shift_out` input 1, strobe: `sbit` is valid this cycle.
- `sbit` input 1, serial result bit, LSB first.
- `carry_in` input 1, final ALU carry; sampled only on commit.
- `load_out` input 1, commit request from the control FSM.
- `clr_err` input 1, synchronous clear of `frame_err` and `overrun`.
- `rd_ready` input 1, consumer accepts `result` this cycle.
- `result` output WIDTH, committed result word.
- `carry_flag` output 1, carry captured with `result`.
- `zero_flag` output 1, 1 when `result == 0`.
- `res_valid` output 1, `result`, `carry_flag` and `zero_flag` are valid.
- `busy` output 1, 1 while in S_COLLECT or S_FULL.
- `frame_err` output 1, sticky; set on a malformed frame.
- `overrun` output 1, sticky; set when a commit is dropped.

## Operation
- States: S_IDLE, S_COLLECT, S_FULL.
- Internal shift register `sr[WIDTH-1:0]` and bit counter `cnt`, width `$clog2(WIDTH+1)`.
- S_IDLE:
  - `shift_out` loads `sr <= {sbit, sr[WIDTH-1:1]}` and sets `cnt <= 1`.
  - Goes to S_COLLECT, or to S_FULL when WIDTH==1.
- S_COLLECT:
  - Each `shift_out` shifts and increments `cnt`.
  - When `cnt` reaches WIDTH, goes to S_FULL.
- S_FULL, `load_out`: commit, then go to S_IDLE.
- S_FULL, `shift_out` without `load_out`: set `frame_err`, discard the frame, go to S_IDLE.
- Commit:
  - `result <= sr`, `carry_flag <= carry_in`, `zero_flag <= (sr == 0)`, `res_valid <= 1`.
  - After WIDTH bits, `sr` holds bit 0 in `sr[0]`.
- Early `load_out` (S_IDLE, or S_COLLECT with `cnt < WIDTH`, last-bit case excepted): set `frame_err`, discard, go to S_IDLE, no commit.
- Last-bit shortcut: in S_COLLECT with `cnt == WIDTH-1`, `shift_out && load_out` in the same cycle commits the word including that bit, then goes to S_IDLE.
- Handshake:
  - `res_valid` stays high until a clock edge with `rd_ready=1`, then clears.
  - `result` is stable while `res_valid=1`.
- Commit while `res_valid && !rd_ready`: the new word is dropped, `overrun` is set, and the output register is unchanged.
- Commit on the same edge as `rd_ready=1` with `res_valid=1`: the new word is accepted and `res_valid` stays 1.
- `clr_err` clears both sticky flags; a set event in the same cycle wins.
- Width rules:
  - `cnt` never exceeds WIDTH.
  - `zero_flag` ignores `carry_in`.

## Timing
- Reset values:
  - state S_IDLE; `sr`, `cnt`, `result` all 0.
  - `carry_flag`=0, `zero_flag`=0, `res_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
- Reset mid-frame aborts immediately: no commit, all outputs return to reset values.
- Shift latency: 1 cycle per strobe; `shift_out` need not be contiguous.
- Commit latency: `res_valid` rises on the edge that samples `load_out`, i.e. visible the following cycle.
- Throughput: back-to-back frames need no idle cycle. A `shift_out` in the cycle after commit starts the next frame.
- `busy` is registered state decode, with no combinational path from inputs.
- All outputs are registered.

## Structure
- Shared package `cpu_pkg`:
  - `rdes_state_t` enum {S_IDLE, S_COLLECT, S_FULL}.
  - `DATA_W` constant (8), used as the WIDTH default.
- One sub-module, `deser_shreg`: parameterised WIDTH shift register with shift enable and LSB-first input.
- Top level holds the FSM, counter, output register and flags.

## Test plan
- WIDTH=8, shift bits 1,0,1,0,0,1,0,1 (0xA5 LSB-first), then `load_out` with `carry_in=1`, `rd_ready=1` -> next cycle `result=0xA5`, `carry_flag=1`, `zero_flag=0`, `res_valid=1` for one cycle.
- Eight 0 bits with gaps of 0–3 idle cycles between strobes, then `load_out` -> `result=0x00`, `zero_flag=1`; `busy` high from the first strobe until commit.
- 7 bits then `shift_out` and `load_out` together with `sbit=1` -> commit, `result[7]=1`, no error.
- 5 bits then `load_out` -> `frame_err=1`, `res_valid` stays 0. `clr_err` -> `frame_err=0`.
- Commit 0x3C with `rd_ready=0`, then a second frame 0x55 committed -> `result` stays 0x3C, `overrun=1`. Raise `rd_ready` -> `res_valid` drops.
- Assert `rstn=0` after 4 bits -> all outputs reset. A fresh 0x81 frame then commits correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the bit-serial CPU blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

  // Datapath width of the bit-serial CPU; default result width.
  localparam int DATA_W = 8;

  // Result receiver framing states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } rdes_state_t;

endpackage

// File: rtl/deser_shreg.sv
// Purpose: LSB-first serial-in shift register, one bit per enabled cycle.
// Latency: 1 cycle per shifted bit; o_sr_next shows the word after a shift this cycle.
// Backpressure: none; shifts whenever i_shift_en is high.
module deser_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_shift_en,
  input  logic             i_sbit,
  output logic [WIDTH-1:0] o_sr,
  output logic [WIDTH-1:0] o_sr_next
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits in sr[0].
  always_comb begin
    w_sr_next            = r_sr >> 1;
    w_sr_next[WIDTH-1]   = i_sbit;
  end

  // Shift register state; contents are only meaningful once a frame is complete.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr <= '0;
    end else if (i_shift_en) begin
      r_sr <= w_sr_next;
    end
  end

  assign o_sr      = r_sr;
  assign o_sr_next = w_sr_next;

endmodule

// File: rtl/result_deser.sv
// Purpose: assembles the LSB-first result stream into a word and holds it for the host.
// Latency: 1 cycle per bit; res_valid visible the cycle after the edge sampling load_out.
// Backpressure: valid/ready output; a commit while the held word is unaccepted is dropped and flags overrun.
module result_deser
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_out,
  input  logic             sbit,
  input  logic             carry_in,
  input  logic             load_out,
  input  logic             clr_err,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             res_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  rdes_state_t      r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_shift_en;
  rdes_state_t      w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_commit_req;
  logic [WIDTH-1:0] w_commit_word;
  logic             w_ferr_set;
  logic             w_accept;
  logic             w_ovr_set;

  // A shift in S_FULL is a framing error, so the completed word is left untouched.
  assign w_shift_en = shift_out && (r_state != S_FULL);

  deser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk        (clk),
    .rstn       (rstn),
    .i_shift_en (w_shift_en),
    .i_sbit     (sbit),
    .o_sr       (w_sr),
    .o_sr_next  (w_sr_next)
  );

  // Framing decode: next state, bit count, commit request and malformed-frame detection.
  // S_IDLE behaves as S_COLLECT with a count of zero, which also covers WIDTH==1.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_commit_req  = 1'b0;
    w_commit_word = w_sr;
    w_ferr_set    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (load_out) begin
          if (shift_out && (r_cnt == CNT_LAST)) begin
            w_commit_req  = 1'b1;
            w_commit_word = w_sr_next;
          end else begin
            w_ferr_set = 1'b1;
          end
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (shift_out) begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = (r_cnt == CNT_LAST) ? S_FULL : S_COLLECT;
        end
      end
      S_FULL: begin
        if (load_out) begin
          w_commit_req = 1'b1;
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
        end else if (shift_out) begin
          w_ferr_set  = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A commit lands unless the held word is still pending and not being taken this edge.
  assign w_accept  = w_commit_req && !(r_valid && !rd_ready);
  assign w_ovr_set = w_commit_req && r_valid && !rd_ready;

  // Framing FSM: state, bit counter and the registered busy decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Output register and valid/ready handshake; contents change only on an accepted commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_commit_word;
      r_carry  <= carry_in;
      r_zero   <= (w_commit_word == '0);
      r_valid  <= 1'b1;
    end else if (r_valid && rd_ready) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign result     = r_result;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign res_valid  = r_valid;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_result_deser.sv
// Purpose: scoreboard bench for result_deser against a bit-list reference model.
// Latency: expects results one cycle after the commit edge.
// Backpressure: drives rd_ready both fixed and random.
module tb_result_deser;
  import cpu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         shift_out, sbit, carry_in, load_out, clr_err, rd_ready;
  logic [W-1:0] result;
  logic         carry_flag, zero_flag, res_valid, busy, frame_err, overrun;

  int n_checks = 0;
  int n_err    = 0;
  bit g_rnd_rd = 1'b0;

  // Reference model: the frame is a list of received bits; output slot is a few plain values.
  typedef struct {
    logic [W-1:0] w;
    bit           c;
    bit           z;
  } exp_t;

  bit           m_bits[$];
  bit           m_valid, m_carry, m_zero, m_ferr, m_ovr;
  logic [W-1:0] m_result;
  exp_t         sbq[$];

  always #5 clk = ~clk;

  result_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .shift_out  (shift_out),
    .sbit       (sbit),
    .carry_in   (carry_in),
    .load_out   (load_out),
    .clr_err    (clr_err),
    .rd_ready   (rd_ready),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .res_valid  (res_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    sbq.delete();
    m_valid  = 0;
    m_carry  = 0;
    m_zero   = 0;
    m_ferr   = 0;
    m_ovr    = 0;
    m_result = '0;
  endfunction

  // One clock of model behaviour, evaluated from the framing rules on the bit list.
  function automatic void model_step(bit sh, bit sb, bit ld, bit cy, bit rd, bit clr);
    int           n   = m_bits.size();
    bit           acc = 0;
    bit           fset = 0;
    bit           oset = 0;
    logic [W-1:0] w   = '0;
    if (ld) begin
      if ((n == W) || (n == W - 1 && sh)) begin
        if (n == W - 1) m_bits.push_back(sb);
        foreach (m_bits[i]) w[i] = m_bits[i];
        if (m_valid && !rd) oset = 1;
        else acc = 1;
      end else begin
        fset = 1;
      end
      m_bits.delete();
    end else if (sh) begin
      if (n == W) begin
        fset = 1;
        m_bits.delete();
      end else begin
        m_bits.push_back(sb);
      end
    end
    if (acc) begin
      m_valid  = 1;
      m_result = w;
      m_carry  = cy;
      m_zero   = (w == 0);
      sbq.push_back('{w: w, c: cy, z: (w == 0)});
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
    if (clr) begin
      m_ferr = 0;
      m_ovr  = 0;
    end
    if (fset) m_ferr = 1;
    if (oset) m_ovr = 1;
  endfunction

  task automatic check_state();
    chk("res_valid",  res_valid,  m_valid);
    chk("busy",       busy,       m_bits.size() != 0);
    chk("frame_err",  frame_err,  m_ferr);
    chk("overrun",    overrun,    m_ovr);
    chk("result",     result,     m_result);
    chk("carry_flag", carry_flag, m_carry);
    chk("zero_flag",  zero_flag,  m_zero);
  endtask

  task automatic step(input bit sh, input bit sb, input bit ld, input bit cy, input bit rd, input bit clr);
    bit r;
    r = g_rnd_rd ? 1'($urandom_range(0, 1)) : rd;
    shift_out = sh;
    sbit      = sb;
    load_out  = ld;
    carry_in  = cy;
    rd_ready  = r;
    clr_err   = clr;
    model_step(sh, sb, ld, cy, r, clr);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input int n, input bit rd);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, rd, 0);
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int n, input int gapmax, input bit rd);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(0, gapmax)), rd);
      step(1, v[i], 0, 0, rd, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"},    result,     '0);
    chk({tag, "_carry"},     carry_flag, 1'b0);
    chk({tag, "_zero"},      zero_flag,  1'b0);
    chk({tag, "_valid"},     res_valid,  1'b0);
    chk({tag, "_busy"},      busy,       1'b0);
    chk({tag, "_frame_err"}, frame_err,  1'b0);
    chk({tag, "_overrun"},   overrun,    1'b0);
  endtask

  task automatic mid_reset();
    #2;
    rstn      = 1'b0;
    shift_out = 0; sbit = 0; load_out = 0; carry_in = 0; rd_ready = 0; clr_err = 0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: every handshake transfer pops the oldest expected result.
  always @(negedge clk) begin
    if (rstn === 1'b1 && res_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got result %0h, expected none", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_result", result, e.w);
        chk("sb_carry",  carry_flag, e.c);
        chk("sb_zero",   zero_flag, e.z);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    int           kind;
    rstn = 1'b0;
    shift_out = 0; sbit = 0; load_out = 0; carry_in = 0; rd_ready = 0; clr_err = 0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2, 1);

    // 0xA5 LSB-first, commit with carry and consumer ready.
    send_bits(8'hA5, 8, 0, 1);
    step(0, 0, 1, 1, 1, 0);
    chk("a5_result", result, 8'hA5);
    idle(2, 1);

    // All-zero word with gaps; carry set to show zero_flag ignores it.
    send_bits(8'h00, 8, 3, 1);
    step(0, 0, 1, 1, 1, 0);
    chk("zero_flag_direct", zero_flag, 1'b1);
    idle(1, 1);

    // Last-bit shortcut: 7 bits, then shift and load together with sbit=1.
    send_bits(8'h13, 7, 1, 1);
    step(1, 1, 1, 0, 1, 0);
    chk("shortcut_msb", result[7], 1'b1);
    chk("shortcut_noerr", frame_err, 1'b0);
    idle(1, 1);

    // Early load after 5 bits, then clear.
    send_bits(8'h1F, 5, 0, 1);
    step(0, 0, 1, 0, 1, 0);
    idle(1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Extra shift in the full state; then load in idle while clearing (set wins).
    send_bits(8'h77, 8, 0, 1);
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Overrun: 0x3C held, 0x55 committed while not ready.
    send_bits(8'h3C, 8, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    send_bits(8'h55, 8, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("ovr_hold", result, 8'h3C);
    idle(2, 1);
    step(0, 0, 0, 0, 1, 1);

    // Back-to-back frames with commit accepted on the same edge as ready.
    send_bits(8'hC3, 8, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    send_bits(8'h0F, 8, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    chk("b2b_result", result, 8'h0F);
    idle(1, 1);

    // Reset mid-frame, then a fresh 0x81 frame.
    send_bits(8'hFF, 4, 0, 1);
    mid_reset();
    send_bits(8'h81, 8, 0, 1);
    step(0, 0, 1, 0, 1, 0);
    chk("post_rst_result", result, 8'h81);
    idle(2, 1);

    // Randomised frames, gaps, backpressure and error injection.
    g_rnd_rd = 1'b1;
    for (int f = 0; f < 200; f++) begin
      v    = W'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind <= 6) begin
        send_bits(v, 8, 2, 0);
        idle(int'($urandom_range(0, 1)), 0);
        step(0, 0, 1, 1'($urandom_range(0, 1)), 0, 0);
      end else if (kind == 7) begin
        send_bits(v, 7, 1, 0);
        step(1, v[7], 1, 1'($urandom_range(0, 1)), 0, 0);
      end else if (kind == 8) begin
        send_bits(v, int'($urandom_range(0, 7)), 1, 0);
        step(0, 0, 1, 0, 0, 0);
      end else begin
        send_bits(v, 8, 0, 0);
        step(1, 0, 0, 0, 0, 0);
      end
      if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0, 0, 1);
    end
    g_rnd_rd = 1'b0;
    idle(3, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
